// File: rtl/convcor_pkg.sv
// Shared types and constants for the CONVCOR stimulus driver.
// Holds FSM encoding, operand bundle and default burst sizes.
package convcor_pkg;

    localparam int CPLX_W       = 16;
    localparam int RSLT_W       = 36;
    localparam int DEF_CONV_LEN = 5;
    localparam int DEF_CORR_LEN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_COLLECT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [CPLX_W-1:0] a;
        logic [CPLX_W-1:0] b;
    } opnd_t;

endpackage

// File: rtl/convcor_if.sv
// Stream link between the driver (master) and CONVCOR (slave).
interface convcor_if;
    import convcor_pkg::*;

    logic              in_valid;
    logic [CPLX_W-1:0] in_a;
    logic [CPLX_W-1:0] in_b;
    logic              in_mode;
    logic              out_valid;
    logic [RSLT_W-1:0] out;

    modport master (
        output in_valid, in_a, in_b, in_mode,
        input  out_valid, out
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode,
        output out_valid, out
    );

endinterface

// File: rtl/convcor_rslt_buf.sv
// 8x36 result register file: sync write, sync clear, registered read.
module convcor_rslt_buf
    import convcor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [RSLT_W-1:0] wdata,
    input  logic              re,
    input  logic [2:0]        raddr,
    output logic [RSLT_W-1:0] rdata
);

    logic [RSLT_W-1:0] mem_q [8];
    logic [RSLT_W-1:0] mem_d [8];
    logic [RSLT_W-1:0] rdata_q, rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < 8; i++) mem_d[i] = '0;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
        // re low masks slots beyond the expected result count
        rdata_d = re ? mem_q[raddr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/convcor_driver.sv
// Host-side driver: replays a buffered operand burst into CONVCOR
// and collects the result burst into a readable buffer.
module convcor_driver
    import convcor_pkg::*;
#(
    parameter int BURST_LEN = 3,
    parameter int CONV_LEN  = DEF_CONV_LEN,
    parameter int CORR_LEN  = DEF_CORR_LEN,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [CPLX_W-1:0] wr_a,
    input  logic [CPLX_W-1:0] wr_b,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    input  logic [2:0]        rd_idx,
    output logic [RSLT_W-1:0] rd_data,
    convcor_if.master         cc
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN);
    localparam logic [TW-1:0] TMO       = TW'(TIMEOUT);

    state_e            state_q, state_d;
    opnd_t             op_q [BURST_LEN];
    opnd_t             op_d [BURST_LEN];
    logic              mode_q, mode_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [1:0]        err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              vld_q, vld_d;
    logic              md_q, md_d;
    logic [CPLX_W-1:0] a_q, a_d;
    logic [CPLX_W-1:0] b_q, b_d;

    logic [3:0]        exp_n;
    logic              buf_clr;
    logic              buf_we;
    logic              buf_re;
    logic [2:0]        buf_waddr;

    assign exp_n  = mode_q ? 4'(CORR_LEN) : 4'(CONV_LEN);
    assign buf_re = {1'b0, rd_idx} < exp_n;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mode_d    = mode_q;
        beat_d    = beat_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        vld_d     = 1'b0;
        md_d      = 1'b0;
        a_d       = '0;
        b_d       = '0;
        buf_clr   = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = rcnt_q[2:0];

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (wr_en && (int'(wr_idx) < BURST_LEN)) begin
                    op_d[wr_idx] = '{a: wr_a, b: wr_b};
                end
                // beat 0 loads from op_d so a same-cycle write is seen
                if (start) begin
                    mode_d  = mode;
                    err_d   = '0;
                    buf_clr = 1'b1;
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    md_d    = mode;
                    a_d     = op_d[0].a;
                    b_d     = op_d[0].b;
                    beat_d  = BW'(1);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_q < LAST_BEAT) begin
                    vld_d  = 1'b1;
                    a_d    = op_q[beat_q].a;
                    b_d    = op_q[beat_q].b;
                    beat_d = beat_q + BW'(1);
                end else begin
                    wcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cc.out_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = 3'd0;
                    rcnt_d    = 4'd1;
                    if (exp_n == 4'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (wcnt_q == TMO) begin
                    err_d[0] = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            ST_COLLECT: begin
                if (cc.out_valid) begin
                    buf_we = 1'b1;
                    rcnt_d = rcnt_q + 4'd1;
                    if (rcnt_q + 4'd1 == exp_n) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    err_d[1] = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < BURST_LEN; i++) op_q[i] <= '0;
            mode_q  <= 1'b0;
            beat_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            md_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            md_q    <= md_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    convcor_rslt_buf u_rslt_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (buf_clr),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (cc.out),
        .re    (buf_re),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cc.in_valid = vld_q;
    assign cc.in_a     = a_q;
    assign cc.in_b     = b_q;
    assign cc.in_mode  = md_q;

endmodule
